// File: rtl/spi_pkg.sv
// Shared SPI master definitions: opcode width, commtype encodings, FSM state
// encoding and the commtype-to-phase decoder.
package spi_pkg;

    localparam int unsigned OPCODE_W = 8;

    typedef enum logic [2:0] {
        CtCmd    = 3'b000,
        CtCmdRx  = 3'b001,
        CtAddrRx = 3'b010,
        CtCmdTx  = 3'b011,
        CtAddrTx = 3'b100,
        CtAddr   = 3'b101,
        CtFastRd = 3'b110,
        CtRsvd   = 3'b111
    } commtype_e;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StAddr,
        StDummy,
        StTx,
        StRx,
        StDone
    } state_e;

    typedef struct packed {
        logic addr;
        logic dummy;
        logic tx;
        logic rx;
    } phases_t;

    // The reserved encoding falls through to command-only.
    function automatic phases_t decode_commtype(logic [2:0] ct);
        phases_t ph;
        ph = '0;
        case (commtype_e'(ct))
            CtCmdRx:  ph.rx = 1'b1;
            CtAddrRx: begin ph.addr = 1'b1; ph.rx = 1'b1; end
            CtCmdTx:  ph.tx = 1'b1;
            CtAddrTx: begin ph.addr = 1'b1; ph.tx = 1'b1; end
            CtAddr:   ph.addr = 1'b1;
            CtFastRd: begin ph.addr = 1'b1; ph.dummy = 1'b1; ph.rx = 1'b1; end
            default:  ph = '0;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/spi_sclk_gen.sv
// SPI clock divider: sclk toggles every DIV_HALF clk cycles while en is high,
// idles low otherwise; rise/fall strobe the clk edge on which sclk changes.
module spi_sclk_gen #(
    parameter int unsigned DIV_HALF = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);

    localparam logic [7:0] LAST = 8'(DIV_HALF - 1);

    logic [7:0] cnt_q, cnt_d;
    logic       sclk_q, sclk_d;
    logic       wrap;

    assign wrap = en && (cnt_q == LAST);
    assign rise = wrap && !sclk_q;
    assign fall = wrap && sclk_q;
    assign sclk = sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else if (wrap) begin
            cnt_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_flex.sv
// Mode-0 SPI flash master: opcode, optional address, dummy and data phases
// selected per request. Fast-read dummy cycles exist only with SPI_MASTER_FLEX_DUMMY_EN.
module spi_master_flex
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 24,
    parameter int unsigned DIV_HALF  = 1,
    parameter int unsigned DUMMY_CYC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [7:0]        command,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data_in,
    input  logic [2:0]        commtype,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    output logic              sclk,
    output logic              ss,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
    localparam int unsigned CNT_W = $clog2(MAX_W);
    localparam logic [7:0]  DONE_LAST = 8'(DIV_HALF - 1);
`ifdef SPI_MASTER_FLEX_DUMMY_EN
    localparam bit DUMMY_ON = (DUMMY_CYC != 0);
`else
    localparam bit DUMMY_ON = 1'b0 && (DUMMY_CYC != 0);
`endif

    typedef logic [MAX_W-1:0] word_t;
    typedef logic [CNT_W-1:0] cnt_t;

    state_e            state_q, state_d, nxt;
    phases_t           ph_q, ph_d;
    word_t             shreg_q, shreg_d;
    cnt_t              bit_cnt_q, bit_cnt_d;
    logic [7:0]        done_cnt_q, done_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] din_q, din_d, dout_q, dout_d;
    logic              ss_q, ss_d, mosi_q, mosi_d, ready_q, ready_d, dov_q, dov_d;
    logic              sclk_en, rise, fall;

    assign sclk_en = state_q inside {StCmd, StAddr, StDummy, StTx, StRx};

    spi_sclk_gen #(
        .DIV_HALF(DIV_HALF)
    ) u_sclk_gen (
        .clk (clk),
        .rst (rst),
        .en  (sclk_en),
        .sclk(sclk),
        .rise(rise),
        .fall(fall)
    );

    function automatic state_e next_phase(state_e cur, phases_t ph);
        state_e n;
        n = StDone;
        if (cur == StCmd && ph.addr) n = StAddr;
        else if (cur == StAddr && ph.dummy) n = StDummy;
        else if ((cur == StCmd || cur == StAddr) && ph.tx) n = StTx;
        else if (cur != StTx && cur != StRx && ph.rx) n = StRx;
        return n;
    endfunction

    always_comb begin
        state_d    = state_q;
        ph_d       = ph_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        done_cnt_d = done_cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        dout_d     = dout_q;
        ss_d       = ss_q;
        mosi_d     = mosi_q;
        ready_d    = ready_q;
        dov_d      = 1'b0;
        nxt        = StDone;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid && ready_q) begin
                    ph_d       = decode_commtype(commtype);
                    ph_d.dummy = ph_d.dummy && DUMMY_ON;
                    addr_d     = address;
                    din_d      = data_in;
                    shreg_d    = word_t'(command) << (MAX_W - OPCODE_W);
                    mosi_d     = command[OPCODE_W-1];
                    bit_cnt_d  = cnt_t'(OPCODE_W - 1);
                    ss_d       = 1'b0;
                    ready_d    = 1'b0;
                    state_d    = StCmd;
                end
            end
            StCmd, StAddr, StDummy, StTx, StRx: begin
                if (rise && state_q == StRx) shreg_d = {shreg_q[MAX_W-2:0], miso};
                if (fall) begin
                    if (bit_cnt_q != '0) begin
                        bit_cnt_d = bit_cnt_q - cnt_t'(1);
                        if (state_q != StRx && state_q != StDummy) begin
                            shreg_d = shreg_q << 1;
                            mosi_d  = shreg_q[MAX_W-2];
                        end
                    end else begin
                        // Phase boundary: preload the next phase's first bit on this fall.
                        nxt     = next_phase(state_q, ph_q);
                        state_d = nxt;
                        shreg_d = '0;
                        mosi_d  = 1'b0;
                        case (nxt)
                            StAddr: begin
                                shreg_d   = word_t'(addr_q) << (MAX_W - ADDR_W);
                                mosi_d    = addr_q[ADDR_W-1];
                                bit_cnt_d = cnt_t'(ADDR_W - 1);
                            end
`ifdef SPI_MASTER_FLEX_DUMMY_EN
                            StDummy: bit_cnt_d = cnt_t'(DUMMY_CYC - 1);
`endif
                            StTx: begin
                                shreg_d   = word_t'(din_q) << (MAX_W - DATA_W);
                                mosi_d    = din_q[DATA_W-1];
                                bit_cnt_d = cnt_t'(DATA_W - 1);
                            end
                            StRx: bit_cnt_d = cnt_t'(DATA_W - 1);
                            default: begin
                                ss_d       = 1'b1;
                                done_cnt_d = '0;
                                if (ph_q.rx) begin
                                    dout_d = shreg_q[DATA_W-1:0];
                                    dov_d  = 1'b1;
                                end
                            end
                        endcase
                    end
                end
            end
            StDone: begin
                if (done_cnt_q == DONE_LAST) begin
                    state_d = StIdle;
                    ready_d = 1'b1;
                end else begin
                    done_cnt_d = done_cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            ph_q       <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            done_cnt_q <= '0;
            addr_q     <= '0;
            din_q      <= '0;
            dout_q     <= '0;
            ss_q       <= 1'b1;
            mosi_q     <= 1'b0;
            ready_q    <= 1'b1;
            dov_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            done_cnt_q <= done_cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            dout_q     <= dout_d;
            ss_q       <= ss_d;
            mosi_q     <= mosi_d;
            ready_q    <= ready_d;
            dov_q      <= dov_d;
        end
    end

    assign cmd_ready      = ready_q;
    assign data_out       = dout_q;
    assign data_out_valid = dov_q;
    assign ss             = ss_q;
    assign mosi           = mosi_q;

endmodule

// File: tb/tb_spi_master_flex.sv
// Scoreboard bench for spi_master_flex: two instances (default and DIV_HALF=3/ADDR_W=32),
// a flash-slave model driving miso, and a monitor checking each ss-low frame.
module tb_spi_master_flex;

    typedef struct {
        int           n_sclk;
        logic [127:0] bits;
        logic [127:0] mask;
        int           period;
        logic         exp_dov;
        logic [31:0]  exp_dout;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [7:0]  command   = '0;
    logic [31:0] address   = '0;
    logic [31:0] data_in   = '0;
    logic [2:0]  commtype  = '0;
    logic        miso      = 1'b1;
    logic        sel       = 1'b0;

    logic        ready0, dov0, sclk0, ss0, mosi0;
    logic        ready1, dov1, sclk1, ss1, mosi1;
    logic [31:0] dout0, dout1;
    logic        ready_m, dov_m, sclk_m, ss_m, mosi_m;
    logic [31:0] dout_m;

    assign ready_m = sel ? ready1 : ready0;
    assign dov_m   = sel ? dov1 : dov0;
    assign sclk_m  = sel ? sclk1 : sclk0;
    assign ss_m    = sel ? ss1 : ss0;
    assign mosi_m  = sel ? mosi1 : mosi0;
    assign dout_m  = sel ? dout1 : dout0;

    always #5 clk = ~clk;

    spi_master_flex #(
        .DATA_W(32), .ADDR_W(24), .DIV_HALF(1), .DUMMY_CYC(8)
    ) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && !sel), .cmd_ready(ready0),
        .command(command), .address(address[23:0]), .data_in(data_in), .commtype(commtype),
        .data_out(dout0), .data_out_valid(dov0), .sclk(sclk0), .ss(ss0), .mosi(mosi0),
        .miso(miso)
    );

    spi_master_flex #(
        .DATA_W(32), .ADDR_W(32), .DIV_HALF(3), .DUMMY_CYC(8)
    ) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid && sel), .cmd_ready(ready1),
        .command(command), .address(address), .data_in(data_in), .commtype(commtype),
        .data_out(dout1), .data_out_valid(dov1), .sclk(sclk1), .ss(ss1), .mosi(mosi1),
        .miso(miso)
    );

    int tests = 0;
    int fails = 0;

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_wide(input string name, input logic [127:0] act,
                              input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard and monitor
    exp_t         sb[$];
    exp_t         cur;
    int           cyc = 0, rises = 0, falls = 0, first_rise = 0, period_meas = 0;
    int           dov_cnt = 0, window = 0, idx = 0;
    logic         active = 1'b0, prev_ss = 1'b1, prev_sclk = 1'b0;
    logic [127:0] cap = '0;
    int           rx_start = 1000;
    logic [31:0]  rdata = '0;

    always @(negedge clk) begin
        cyc++;
        if (active && !prev_sclk && sclk_m) begin
            cap[rises] = mosi_m;
            if (rises == 0) first_rise = cyc;
            else if (rises == 1) period_meas = cyc - first_rise;
            rises++;
        end
        if (active && prev_sclk && !sclk_m) falls++;
        if (dov_m) dov_cnt++;
        if (prev_ss && !ss_m) begin
            active = 1'b1; rises = 0; falls = 0; cap = '0; dov_cnt = 0; period_meas = 0;
        end
        if (!prev_ss && ss_m && active) begin
            active = 1'b0;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got %0d sclk cycles expected no frame", rises);
            end else begin
                cur = sb.pop_front();
                if (cur.n_sclk >= 0) begin
                    check_int("sclk_rises", rises, cur.n_sclk);
                    check_int("sclk_falls", falls, rises);
                    check_wide("mosi_bits", cap & cur.mask, cur.bits & cur.mask);
                    check_int("sclk_period", period_meas, cur.period);
                end
                window = 20;
            end
        end
        if (window > 0) begin
            window--;
            if (window == 0) begin
                check_int("dov_pulses", dov_cnt, int'(cur.exp_dov));
                check_word("data_out", dout_m, cur.exp_dout);
                check_bit("ready_after", ready_m, 1'b1);
                check_bit("sclk_idle", sclk_m, 1'b0);
            end
        end
        // Flash slave: next bit is presented well ahead of the next rising edge.
        idx = rises;
        miso = (idx >= rx_start && idx < rx_start + 32) ? rdata[31 - (idx - rx_start)] : 1'b1;
        prev_ss   = ss_m;
        prev_sclk = sclk_m;
    end

    // Expected-frame builder
    exp_t eb;

    task automatic exp_start(input int div, input logic dov, input logic [31:0] dout);
        eb.n_sclk = 0; eb.bits = '0; eb.mask = '0;
        eb.period = 2 * div; eb.exp_dov = dov; eb.exp_dout = dout;
    endtask

    task automatic exp_add(input logic [31:0] v, input int w, input logic chk);
        for (int i = 0; i < w; i++) begin
            eb.bits[eb.n_sclk + i] = v[w - 1 - i];
            eb.mask[eb.n_sclk + i] = chk;
        end
        eb.n_sclk += w;
    endtask

    task automatic issue(input logic s, input logic [7:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] ct, input int rxs,
                         input logic [31:0] rd);
        int n;
        sel = s;
        n = 0;
        @(negedge clk);
        while (!ready_m && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!ready_m) begin
            tests++;
            fails++;
            $display("FAIL ready_timeout: got cmd_ready=0 expected 1 within 1000 cycles");
        end
        rx_start = rxs;
        rdata    = rd;
        sb.push_back(eb);
        command = c; address = a; data_in = d; commtype = ct;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!(ready_m && ss_m && !active && window == 0 && sb.size() == 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            tests++;
            fails++;
            $display("FAIL idle_timeout: got %0d frames pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    logic [31:0] last0 = '0, last1 = '0;

    initial begin
        repeat (3) @(negedge clk);
        check_bit("rst_ss", ss0, 1'b1);
        check_bit("rst_sclk", sclk0, 1'b0);
        check_bit("rst_mosi", mosi0, 1'b0);
        check_bit("rst_ready", ready0, 1'b1);
        check_word("rst_dout", dout0, 32'h0);
        check_bit("rst_dov", dov0, 1'b0);
        check_bit("rst_ss1", ss1, 1'b1);
        check_bit("rst_ready1", ready1, 1'b1);
        rst = 1'b0;
        @(negedge clk);

        // Command only
        exp_start(1, 1'b0, last0); exp_add(32'h06, 8, 1'b1);
        issue(1'b0, 8'h06, 32'h0, 32'h0, 3'b000, 1000, 32'h0);
        wait_idle();

        // Read with address
        exp_start(1, 1'b1, 32'hDEADBEEF);
        exp_add(32'h03, 8, 1'b1); exp_add(32'h012345, 24, 1'b1); exp_add(32'h0, 32, 1'b0);
        issue(1'b0, 8'h03, 32'h012345, 32'h0, 3'b010, 32, 32'hDEADBEEF);
        wait_idle();
        last0 = 32'hDEADBEEF;

        // Page program
        exp_start(1, 1'b0, last0);
        exp_add(32'h02, 8, 1'b1); exp_add(32'h000100, 24, 1'b1); exp_add(32'hA5A50F0F, 32, 1'b1);
        issue(1'b0, 8'h02, 32'h000100, 32'hA5A50F0F, 3'b100, 1000, 32'h0);
        wait_idle();

        // Fast read
        exp_start(1, 1'b1, 32'h12345678);
        exp_add(32'h0B, 8, 1'b1); exp_add(32'h00ABCD, 24, 1'b1);
`ifdef SPI_MASTER_FLEX_DUMMY_EN
        exp_add(32'h0, 8, 1'b1); exp_add(32'h0, 32, 1'b0);
        issue(1'b0, 8'h0B, 32'h00ABCD, 32'h0, 3'b110, 40, 32'h12345678);
`else
        exp_add(32'h0, 32, 1'b0);
        issue(1'b0, 8'h0B, 32'h00ABCD, 32'h0, 3'b110, 32, 32'h12345678);
`endif
        wait_idle();
        last0 = 32'h12345678;

        // Command + read
        exp_start(1, 1'b1, 32'hC2201600); exp_add(32'h9F, 8, 1'b1); exp_add(32'h0, 32, 1'b0);
        issue(1'b0, 8'h9F, 32'h0, 32'h0, 3'b001, 8, 32'hC2201600);
        wait_idle();
        last0 = 32'hC2201600;

        // Command + write
        exp_start(1, 1'b0, last0); exp_add(32'h01, 8, 1'b1); exp_add(32'h0000005A, 32, 1'b1);
        issue(1'b0, 8'h01, 32'h0, 32'h0000005A, 3'b011, 1000, 32'h0);
        wait_idle();

        // Command + address
        exp_start(1, 1'b0, last0); exp_add(32'hD8, 8, 1'b1); exp_add(32'hFEDCBA, 24, 1'b1);
        issue(1'b0, 8'hD8, 32'hFEDCBA, 32'h0, 3'b101, 1000, 32'h0);
        wait_idle();

        // Reserved encoding acts as command only
        exp_start(1, 1'b0, last0); exp_add(32'h66, 8, 1'b1);
        issue(1'b0, 8'h66, 32'h123456, 32'hFFFFFFFF, 3'b111, 1000, 32'h0);
        wait_idle();

        // Slow divider, 32-bit address, request while busy ignored
        exp_start(3, 1'b1, 32'h0F1E2D3C);
        exp_add(32'h13, 8, 1'b1); exp_add(32'h89ABCDEF, 32, 1'b1); exp_add(32'h0, 32, 1'b0);
        issue(1'b1, 8'h13, 32'h89ABCDEF, 32'h0, 3'b010, 40, 32'h0F1E2D3C);
        repeat (30) @(negedge clk);
        check_bit("ready_busy", ready_m, 1'b0);
        command = 8'hFF; commtype = 3'b000; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        wait_idle();
        repeat (100) @(negedge clk);
        last1 = 32'h0F1E2D3C;

        // Reset in the middle of a read
        exp_start(1, 1'b0, 32'h0); eb.n_sclk = -1;
        issue(1'b0, 8'h05, 32'h0, 32'h0, 3'b001, 8, 32'hFFFFFFFF);
        for (int n = 0; n < 2000 && !(active && rises >= 20); n++) @(negedge clk);
        check_int("reached_rx", rises, 20);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_bit("abort_ss", ss0, 1'b1);
        check_bit("abort_ready", ready0, 1'b1);
        check_bit("abort_sclk", sclk0, 1'b0);
        check_bit("abort_dov", dov0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last0 = 32'h0;
        last1 = 32'h0;
        wait_idle();

        // Clean restart after reset
        exp_start(1, 1'b1, 32'h000000A5); exp_add(32'h05, 8, 1'b1); exp_add(32'h0, 32, 1'b0);
        issue(1'b0, 8'h05, 32'h0, 32'h0, 3'b001, 8, 32'h000000A5);
        wait_idle();
        last0 = 32'h000000A5;

        exp_start(3, 1'b0, last1); exp_add(32'h06, 8, 1'b1);
        issue(1'b1, 8'h06, 32'h0, 32'h0, 3'b000, 1000, 32'h0);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before 2 ms");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_master_flex.md
SPI_MASTER_FLEX -- requirements
Module: spi_master_flex

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning data word width in bits (multiple of 8, 8..32).
REQ-002 SHALL have parameter ADDR_W, default 24, meaning flash address width in bits (24 or 32).
REQ-003 SHALL have parameter DIV_HALF, default 1, meaning clk cycles per sclk half-period (1..255).
REQ-004 SHALL have parameter DUMMY_CYC, default 8, meaning sclk dummy cycles for commtype 3'b110 (0..31).
REQ-005 SHALL have port clk, input, 1, system clock.
REQ-006 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-007 SHALL have port cmd_valid, input, 1, request present.
REQ-008 SHALL have port cmd_ready, output, 1, block can accept a request.
REQ-009 SHALL have port command, input, 8, SPI opcode.
REQ-010 SHALL have port address, input, ADDR_W, flash address.
REQ-011 SHALL have port data_in, input, DATA_W, write payload.
REQ-012 SHALL have port commtype, input, 3, transaction type.
REQ-013 SHALL have port data_out, output, DATA_W, last read word.
REQ-014 SHALL have port data_out_valid, output, 1, one-clk pulse when data_out updates.
REQ-015 SHALL have ports sclk (output, 1), ss (output, 1, active-low), mosi (output, 1), miso (input, 1).

Function
REQ-016 SHALL accept a request on the clk edge where cmd_valid and cmd_ready are both 1, registering command, address, data_in and commtype.
REQ-017 SHALL set cmd_ready to 0 from the clk edge after acceptance until the DONE state exits; cmd_valid while busy is ignored.
REQ-018 SHALL run all logic on clk; sclk is a registered output that toggles every DIV_HALF clk cycles while active and idles at 0 (SPI mode 0).
REQ-019 SHALL implement FSM states IDLE -> CMD -> [ADDR] -> [DUMMY] -> [TX | RX] -> DONE -> IDLE; bracketed phases are skipped per commtype.
REQ-020 SHALL decode commtype: 000 cmd; 001 cmd+RX; 010 cmd+addr+RX; 011 cmd+TX; 100 cmd+addr+TX; 101 cmd+addr; 110 cmd+addr+DUMMY+RX (fast read); 111 treated as 000.
REQ-021 SHALL drive ss low one clk after acceptance and keep it low until the last sclk falling edge of the final phase, then raise it in DONE for at least DIV_HALF clk cycles.
REQ-022 SHALL shift MSB first: 8 command bits, ADDR_W address bits, DATA_W TX bits; mosi changes only at sclk falling edges (first bit valid before the first rising edge).
REQ-023 SHALL sample miso at sclk rising edges during RX, DATA_W bits MSB first; DUMMY drives mosi 0 for DUMMY_CYC sclk cycles and samples nothing.
REQ-024 SHALL update data_out and pulse data_out_valid for exactly one clk in DONE for RX types only; data_out holds otherwise.
REQ-025 SHALL use a single bit counter sized for max(ADDR_W, DATA_W) reloaded at each phase entry, so no phase wraps.

Reset
REQ-026 SHALL, on rst, force IDLE immediately: ss=1, sclk=0, mosi=0, cmd_ready=1, data_out=0, data_out_valid=0, counters cleared.
REQ-027 SHALL abort an in-flight transaction on rst without emitting data_out_valid; the first accept after reset release starts cleanly.

Configuration
REQ-028 SHALL honour macro SPI_MASTER_FLEX_DUMMY_EN: defined -> commtype 110 performs the DUMMY phase; undefined -> DUMMY logic absent and 110 behaves as 010.

Structure
REQ-029 SHALL take commtype encodings, the FSM state encoding and the opcode width from shared package spi_pkg.
REQ-030 SHALL place sclk generation (divider, rise/fall strobes) in sub-module spi_sclk_gen.

Verification
REQ-031 SHALL cover: commtype 000, command 8'h06 -> ss low for exactly 8 sclk cycles, mosi 0000_0110, no data_out_valid.
REQ-032 SHALL cover: commtype 010, command 8'h03, address 24'h012345, slave returns 32'hDEADBEEF -> 64 sclk cycles, data_out=32'hDEADBEEF, one-clk data_out_valid.
REQ-033 SHALL cover: commtype 100, command 8'h02, address 24'h000100, data_in 32'hA5A5_0F0F -> 64 bits on mosi MSB first, cmd_ready returns 1 after DONE.
REQ-034 SHALL cover: macro defined, commtype 110, DUMMY_CYC 8, command 8'h0B -> 8+24+8+32 sclk cycles, mosi 0 during dummy, correct read word.
REQ-035 SHALL cover: DIV_HALF 3 and ADDR_W 32 -> sclk period 6 clk; second cmd_valid while busy ignored.
REQ-036 SHALL cover: rst asserted mid-RX -> ss=1, cmd_ready=1 the same cycle, no data_out_valid.
